hazard_ctrl: RTL

- Central stall/flush scheduler for the 5-stage pipeline.
- Decides, every cycle, whether the PC and the IF/ID register advance, whether the ID/EX control word is zeroed (bubble), and whether IF/ID is flushed.
- Handles three sources: load-use hazards, taken branches resolved in EX, and multi-cycle multiply/divide instructions held in ID while a fixed-latency unit runs.
- Replaces ad-hoc freeze logic at the ID stage; outputs drive the PC enable, IF/ID write/flush and the ID control mux select.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_md_timer.sv | 35 +++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, MD counter width and the zero-register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MD_ISSUE = 2'd2
  } hz_state_e;

  localparam int MD_CNT_W = 6;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Loadable down-counter that tracks the remaining multiply/divide latency.
// Saturates at zero; zero flags the final busy cycle.
module md_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler: load-use stalls, EX branch flushes, MD holds.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_md_req,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_start,
  output logic        md_abort,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  hz_state_e state_q, state_d;
  logic      lu;
  logic      tmr_load, tmr_dec, tmr_zero;

  assign lu = ex_memread && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  md_timer #(.W(MD_CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (MD_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Priority chain: reset, branch flush, MD hold, load-use, MD accept, normal.
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;
    md_abort    = 1'b0;
    md_busy     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      md_busy     = (state_q == MD_BUSY);
      md_abort    = (state_q == MD_BUSY);
      state_d     = RUN;
    end else if (state_q == MD_BUSY) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      md_busy     = 1'b1;
      tmr_dec     = 1'b1;
      if (tmr_zero) begin
        state_d = MD_ISSUE;
      end
    end else begin
      // MD_ISSUE lets the held MD instruction into EX, so its request is ignored.
      if (state_q == MD_ISSUE) begin
        state_d = RUN;
      end
      if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if ((state_q == RUN) && id_md_req) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        md_start    = 1'b1;
        tmr_load    = 1'b1;
        state_d     = MD_BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
